pcie_dllp_tx_arbiter: RTL

Packet-granular arbiter sharing the single DLLP transmit AXI-stream between three DLLP sources: Ack/Nak generator, flow-control init sequencer, and UpdateFC generator. Sits between those sources and the DLLP framing/CRC path. It grants whole DLLPs by fixed priority, locks the grant until `tlast`, and gates UpdateFC until the link is DL_Active.

---
 rtl/pcie_datalink_pkg.sv | 16 +
 rtl/pcie_dllp_prio_sel.sv | 23 ++
 rtl/pcie_dllp_tx_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/pcie_datalink_pkg.sv
// Shared types and constants for the PCIe data link layer DLLP transmit path.
package pcie_datalink_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_LOCK
  } dllp_arb_state_e;

  localparam logic [1:0] GntAck  = 2'd0;
  localparam logic [1:0] GntFc   = 2'd1;
  localparam logic [1:0] GntUpd  = 2'd2;
  localparam logic [1:0] GntNone = 2'd3;

  localparam int unsigned StarveLimitDefault = 16;

endpackage

// File: rtl/pcie_dllp_prio_sel.sv
// Fixed-priority selector for DLLP sources (ack > fc > upd) with a force-upd override.
module pcie_dllp_prio_sel
  import pcie_datalink_pkg::*;
(
  input  logic [2:0] elig_i,
  input  logic       force_upd_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = GntNone;
    if (force_upd_i && elig_i[2]) begin
      gnt_o = GntUpd;
    end else if (elig_i[0]) begin
      gnt_o = GntAck;
    end else if (elig_i[1]) begin
      gnt_o = GntFc;
    end else if (elig_i[2]) begin
      gnt_o = GntUpd;
    end
  end

endmodule

// File: rtl/pcie_dllp_tx_arbiter.sv
// Packet-granular arbiter merging Ack/Nak, FC init and UpdateFC DLLP streams.
// Optional starvation guard for UpdateFC: define DLLP_ARB_STARVE_EN.
module pcie_dllp_tx_arbiter
  import pcie_datalink_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned KEEP_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned USER_WIDTH   = 3,
  parameter int unsigned STARVE_LIMIT = StarveLimitDefault
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  dl_active_i,

  input  logic [DATA_WIDTH-1:0] s_ack_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_ack_axis_tkeep,
  input  logic                  s_ack_axis_tvalid,
  input  logic                  s_ack_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_ack_axis_tuser,
  output logic                  s_ack_axis_tready,

  input  logic [DATA_WIDTH-1:0] s_fc_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_fc_axis_tkeep,
  input  logic                  s_fc_axis_tvalid,
  input  logic                  s_fc_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_fc_axis_tuser,
  output logic                  s_fc_axis_tready,

  input  logic [DATA_WIDTH-1:0] s_upd_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_upd_axis_tkeep,
  input  logic                  s_upd_axis_tvalid,
  input  logic                  s_upd_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_upd_axis_tuser,
  output logic                  s_upd_axis_tready,

  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  output logic [USER_WIDTH-1:0] m_axis_tuser,
  input  logic                  m_axis_tready,

  output logic [1:0]            grant_o
);

  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("STARVE_LIMIT must be at least 1");
  end

  dllp_arb_state_e state_q, state_d;
  logic [1:0]      grant_q, grant_d;
  logic [2:0]      elig;
  logic [1:0]      sel_gnt;
  logic            force_upd;

  assign elig = {s_upd_axis_tvalid & dl_active_i, s_fc_axis_tvalid, s_ack_axis_tvalid};

  pcie_dllp_prio_sel u_prio_sel (
    .elig_i      (elig),
    .force_upd_i (force_upd),
    .gnt_o       (sel_gnt)
  );

`ifdef DLLP_ARB_STARVE_EN
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  logic [CntW-1:0] starve_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_cnt <= '0;
    end else if (state_q == ST_IDLE && |elig) begin
      if (sel_gnt == GntUpd) begin
        starve_cnt <= '0;
      end else if (elig[2] && starve_cnt != CntW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + 1'b1;
      end
    end
  end

  assign force_upd = (starve_cnt == CntW'(STARVE_LIMIT));
`else
  assign force_upd = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      grant_q <= GntNone;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Output path is a pure mux on the registered owner; nothing is buffered here.
  always_comb begin
    m_axis_tdata      = '0;
    m_axis_tkeep      = '0;
    m_axis_tvalid     = 1'b0;
    m_axis_tlast      = 1'b0;
    m_axis_tuser      = '0;
    s_ack_axis_tready = 1'b0;
    s_fc_axis_tready  = 1'b0;
    s_upd_axis_tready = 1'b0;
    if (state_q == ST_LOCK) begin
      case (grant_q)
        GntAck: begin
          m_axis_tdata      = s_ack_axis_tdata;
          m_axis_tkeep      = s_ack_axis_tkeep;
          m_axis_tvalid     = s_ack_axis_tvalid;
          m_axis_tlast      = s_ack_axis_tlast;
          m_axis_tuser      = s_ack_axis_tuser;
          s_ack_axis_tready = m_axis_tready;
        end
        GntFc: begin
          m_axis_tdata      = s_fc_axis_tdata;
          m_axis_tkeep      = s_fc_axis_tkeep;
          m_axis_tvalid     = s_fc_axis_tvalid;
          m_axis_tlast      = s_fc_axis_tlast;
          m_axis_tuser      = s_fc_axis_tuser;
          s_fc_axis_tready  = m_axis_tready;
        end
        GntUpd: begin
          m_axis_tdata      = s_upd_axis_tdata;
          m_axis_tkeep      = s_upd_axis_tkeep;
          m_axis_tvalid     = s_upd_axis_tvalid;
          m_axis_tlast      = s_upd_axis_tlast;
          m_axis_tuser      = s_upd_axis_tuser;
          s_upd_axis_tready = m_axis_tready;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      ST_IDLE: begin
        if (|elig) begin
          state_d = ST_LOCK;
          grant_d = sel_gnt;
        end
      end
      ST_LOCK: begin
        if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
          state_d = ST_IDLE;
          grant_d = GntNone;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = GntNone;
      end
    endcase
  end

  assign grant_o = grant_q;

endmodule
